cache_miss_fsm: RTL and testbench

// Cache controller FSM directly upstream of each cache set: decodes processor

---
 rtl/cache_miss_fsm.sv | 143 ++++++++++++++
 tb/tb_cache_miss_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cache_miss_fsm.sv
// Cache set controller: decodes hits into the set control word and runs
// the dirty write-back plus line refill against word-wide memory on a miss.
module cache_miss_fsm #(
    parameter int TAG_WIDTH    = 22,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_en_i,
    input  logic                 write_en_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic [5:0]           control_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 stall_o
);

    localparam int CNT_W  = OFFSET_WIDTH - 2;
    localparam int LINE_W = 32 - OFFSET_WIDTH;
    localparam logic [CNT_W-1:0] LAST_WORD = '1;

    localparam logic [5:0] CTRL_READ_HIT  = 6'b000011;
    localparam logic [5:0] CTRL_WRITE_HIT = 6'b101111;
    localparam logic [5:0] CTRL_FILL_WORD = 6'b100000;
    localparam logic [5:0] CTRL_FILL_LAST = 6'b111000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        REFILL     = 2'd2
    } state_t;

    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [LINE_W-1:0]      r_line, w_line_next;
    logic [TAG_WIDTH-1:0]   r_victim_tag, w_victim_tag_next;

    logic                   w_req;
    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_WIDTH-1:0]   w_line_tag;
    logic [5:0]             w_control;
    logic [31:0]            w_mem_addr;
    logic                   w_mem_req;
    logic                   w_mem_we;
    logic                   w_stall;

    assign w_req      = read_en_i | write_en_i;
    assign w_index    = r_line[INDEX_WIDTH-1:0];
    assign w_line_tag = r_line[LINE_W-1:INDEX_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_victim_tag <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_line       <= w_line_next;
            r_victim_tag <= w_victim_tag_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_line_next       = r_line;
        w_victim_tag_next = r_victim_tag;
        w_control         = '0;
        w_mem_addr        = '0;
        w_mem_req         = 1'b0;
        w_mem_we          = 1'b0;
        w_stall           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (hit_i) begin
                        w_control = write_en_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
                    end else begin
                        w_stall           = 1'b1;
                        w_line_next       = addr_i[31:OFFSET_WIDTH];
                        w_victim_tag_next = tag_i;
                        w_cnt_next        = '0;
                        w_state_next      = dirty_i ? WRITE_BACK : REFILL;
                    end
                end
            end

            WRITE_BACK: begin
                // offset_sel stays 0 so the set presents the word at mem_addr's offset
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_stall    = 1'b1;
                w_mem_addr = {r_victim_tag, w_index, r_cnt, 2'b00};
                if (mem_ready_i) begin
                    if (r_cnt == LAST_WORD) begin
                        w_cnt_next   = '0;
                        w_state_next = REFILL;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            REFILL: begin
                w_mem_req  = 1'b1;
                w_stall    = 1'b1;
                w_mem_addr = {w_line_tag, w_index, r_cnt, 2'b00};
                if (mem_ready_i) begin
                    if (r_cnt == LAST_WORD) begin
                        w_control    = CTRL_FILL_LAST;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_control  = CTRL_FILL_WORD;
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Reset silences every output at once, even while a request is still presented.
    assign control_o  = rst_i ? 6'b0  : w_control;
    assign mem_addr_o = rst_i ? 32'b0 : w_mem_addr;
    assign mem_req_o  = rst_i ? 1'b0  : w_mem_req;
    assign mem_we_o   = rst_i ? 1'b0  : w_mem_we;
    assign stall_o    = rst_i ? 1'b0  : w_stall;

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Directed bench for cache_miss_fsm: hits, clean/dirty misses, memory
// back-pressure, dropped request and asynchronous reset mid-refill.
module tb_cache_miss_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        read_en_i = 1'b0;
    logic        write_en_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        hit_i = 1'b0;
    logic        dirty_i = 1'b0;
    logic [21:0] tag_i = 22'h0;
    logic        mem_ready_i = 1'b0;
    logic [5:0]  control_o;
    logic [31:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;

    cache_miss_fsm #(
        .TAG_WIDTH   (22),
        .INDEX_WIDTH (6),
        .OFFSET_WIDTH(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .read_en_i  (read_en_i),
        .write_en_i (write_en_i),
        .addr_i     (addr_i),
        .hit_i      (hit_i),
        .dirty_i    (dirty_i),
        .tag_i      (tag_i),
        .mem_ready_i(mem_ready_i),
        .control_o  (control_o),
        .mem_addr_o (mem_addr_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .stall_o    (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] ctrl, input logic req,
                           input logic we, input logic stall, input logic [31:0] maddr);
        chk({tag, "_ctrl"},  {26'b0, control_o}, {26'b0, ctrl});
        chk({tag, "_req"},   {31'b0, mem_req_o}, {31'b0, req});
        chk({tag, "_we"},    {31'b0, mem_we_o},  {31'b0, we});
        chk({tag, "_stall"}, {31'b0, stall_o},   {31'b0, stall});
        chk({tag, "_maddr"}, mem_addr_o, maddr);
        $display("step %-12s ctrl=%b req=%b we=%b stall=%b maddr=%h", tag,
                 control_o, mem_req_o, mem_we_o, stall_o, mem_addr_o);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state, even with a hit request presented
        read_en_i = 1'b1; hit_i = 1'b1;
        #2;
        chk_all("reset", 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        read_en_i = 1'b0; hit_i = 1'b0;
        #1 rst_i = 1'b0;

        // 1: read hit
        tick();
        read_en_i = 1'b1; addr_i = 32'h0000_1040; hit_i = 1'b1;
        #2 chk_all("rd_hit", 6'b000011, 1'b0, 1'b0, 1'b0, 32'h0);

        // 2: write hit, then write priority when both requests are set
        tick();
        read_en_i = 1'b0; write_en_i = 1'b1;
        #2 chk_all("wr_hit", 6'b101111, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        read_en_i = 1'b1;
        #2 chk_all("rdwr_hit", 6'b101111, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        read_en_i = 1'b0; write_en_i = 1'b0; hit_i = 1'b0;
        #2 chk_all("idle", 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

        // 3: clean read miss at 0x2080, memory always ready
        tick();
        read_en_i = 1'b1; addr_i = 32'h0000_2080; hit_i = 1'b0; dirty_i = 1'b0;
        tag_i = 22'h3F_FFFF; mem_ready_i = 1'b1;
        #2 chk_all("c_miss", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); #2 chk_all("c_rf0", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2080);
        tick(); #2 chk_all("c_rf1", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2084);
        tick(); #2 chk_all("c_rf2", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2088);
        tick(); #2 chk_all("c_rf3", 6'b111000, 1'b1, 1'b0, 1'b1, 32'h0000_208C);
        tick();
        hit_i = 1'b1;
        #2 chk_all("c_retry", 6'b000011, 1'b0, 1'b0, 1'b0, 32'h0);

        // 4: dirty write miss; victim tag 0x00001 with index 8 -> 0x480..0x48C
        tick();
        read_en_i = 1'b0; write_en_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b1;
        tag_i = 22'h00001;
        #2 chk_all("d_miss", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        tag_i = 22'h3F_FFFF; dirty_i = 1'b0;
        #2 chk_all("d_wb0", 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0480);
        tick(); #2 chk_all("d_wb1", 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0484);
        tick(); #2 chk_all("d_wb2", 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_0488);
        tick(); #2 chk_all("d_wb3", 6'b000000, 1'b1, 1'b1, 1'b1, 32'h0000_048C);
        tick(); #2 chk_all("d_rf0", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2080);
        tick(); #2 chk_all("d_rf1", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2084);
        tick(); #2 chk_all("d_rf2", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2088);
        tick(); #2 chk_all("d_rf3", 6'b111000, 1'b1, 1'b0, 1'b1, 32'h0000_208C);
        tick();
        hit_i = 1'b1;
        #2 chk_all("d_retry", 6'b101111, 1'b0, 1'b0, 1'b0, 32'h0);

        // 5: clean miss at 0x3C50 with ready toggling; request dropped mid-refill
        tick();
        write_en_i = 1'b0; read_en_i = 1'b1; addr_i = 32'h0000_3C50;
        hit_i = 1'b0; dirty_i = 1'b0;
        #2 chk_all("t_miss", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); mem_ready_i = 1'b1;
        #2 chk_all("t_rf0_r", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_3C50);
        tick(); mem_ready_i = 1'b0; read_en_i = 1'b0;
        #2 chk_all("t_rf1_w", 6'b000000, 1'b1, 1'b0, 1'b1, 32'h0000_3C54);
        tick(); mem_ready_i = 1'b1;
        #2 chk_all("t_rf1_r", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_3C54);
        tick(); mem_ready_i = 1'b0;
        #2 chk_all("t_rf2_w", 6'b000000, 1'b1, 1'b0, 1'b1, 32'h0000_3C58);
        tick(); mem_ready_i = 1'b1;
        #2 chk_all("t_rf2_r", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_3C58);
        tick(); mem_ready_i = 1'b0;
        #2 chk_all("t_rf3_w", 6'b000000, 1'b1, 1'b0, 1'b1, 32'h0000_3C5C);
        tick(); mem_ready_i = 1'b1;
        #2 chk_all("t_rf3_r", 6'b111000, 1'b1, 1'b0, 1'b1, 32'h0000_3C5C);
        tick();
        #2 chk_all("t_done", 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

        // 6: reset pulsed in REFILL at cnt=2, then the held miss restarts at word 0
        tick();
        read_en_i = 1'b1; addr_i = 32'h0000_2080; hit_i = 1'b0; dirty_i = 1'b0;
        #2 chk_all("r_miss", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); #2 chk_all("r_rf0", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2080);
        tick(); #2 chk_all("r_rf1", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2084);
        tick(); #2 chk_all("r_rf2", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2088);
        rst_i = 1'b1;
        #1 chk_all("r_in_rst", 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 rst_i = 1'b0;
        #1 chk_all("r_after", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); #2 chk_all("r_rerf0", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2080);
        tick(); #2 chk_all("r_rerf1", 6'b100000, 1'b1, 1'b0, 1'b1, 32'h0000_2084);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
